cvm300_sensor_emulator: RTL and testbench
=========================================

// Module: cvm300_sensor_emulator
// PURPOSE
// Transmit side of the CVM300 parallel pixel interface: emulates the image sensor so the
// capture path (FIFO write on Data_valid & Line_valid, BTPipeOut to PC) and the tracking
// software can be exercised without the camera. Answers a FRAME_REQ pulse with one frame of
// Line_valid/Data_valid/D[9:0] traffic carrying a selectable synthetic pattern, including a
// movable bright box used as a tracking target.
// PARAMETERS
// H_ACTIVE   648  pixels per line (Line_valid high cycles)
// V_LINES    488  lines per frame
// H_BLANK    16   idle cycles after each line (Line_valid low)
// FOT_CYCLES 64   cycles from FRAME_REQ rising edge to first Line_valid
// BOX_SIZE   32   edge length in pixels of the target box (pattern 3)
// PORTS
// CVM_Clk            in   1   pixel clock; all logic on rising edge
// reset              in   1   synchronous, active-high
// FRAME_REQ          in   1   frame request from capture FSM; rising edge starts a frame
// pattern_sel        in   2   0 ramp, 1 checker, 2 constant, 3 box
// const_val          in   10  pixel value for pattern 2
// box_x              in   10  box left column (pattern 3)
// box_y              in   10  box top row (pattern 3)
// CVM300_Line_valid  out  1   high for H_ACTIVE consecutive cycles per line
// CVM300_Data_valid  out  1   equals Line_valid (every active cycle carries a pixel)
// CVM300_D           out  10  pixel data; 0 when Line_valid low
// frame_busy         out  1   high from FOT entry until DONE
// frame_done         out  1   one-cycle pulse at end of frame
// req_overrun        out  1   sticky: FRAME_REQ rising edge seen while busy; cleared by reset
// frame_cnt          out  16  frames completed, wraps at 16'hFFFF -> 0
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, x/y/counters 0. Reset mid-frame aborts on the next edge.
// - FRAME_REQ registered once; rise = FRAME_REQ & ~FRAME_REQ_q.
// - IDLE: on rise -> FOT; latch pattern_sel, const_val, box_x, box_y (stable for whole frame).
// - FOT: frame_busy=1; count FOT_CYCLES cycles, then LINE with x=0, y=0. First Line_valid
//   appears FOT_CYCLES+1 cycles after the cycle FRAME_REQ is first sampled high.
// - LINE: Line_valid=Data_valid=1; x increments 0..H_ACTIVE-1; at x=H_ACTIVE-1 -> HBLANK.
// - HBLANK: outputs low for H_BLANK cycles; then if y=V_LINES-1 -> DONE else y++, x=0, LINE.
// - DONE: frame_done=1 for one cycle, frame_busy=0, frame_cnt++; -> IDLE.
// - Rise while not IDLE: ignored, req_overrun<=1. Rise in DONE cycle also ignored (overrun).
// - Pixel (registered with Line_valid, same cycle alignment):
//   0 ramp:    D = (x + y + frame_cnt)[9:0], wraps mod 1024
//   1 checker: D = (x[3]^y[3]) ? 10'h3FF : 10'h000
//   2 const:   D = const_val
//   3 box:     D = 10'h3FF if box_x<=x<box_x+BOX_SIZE and box_y<=y<box_y+BOX_SIZE, else 10'h040;
//              comparisons in 11 bits so a box at the right/bottom edge clips, never wraps.
// - Frame = V_LINES*(H_ACTIVE+H_BLANK) cycles after FOT; exactly H_ACTIVE*V_LINES valid pixels.
// TESTING (H_ACTIVE=8, V_LINES=4, H_BLANK=3, FOT_CYCLES=5, BOX_SIZE=2)
// - Reset, FRAME_REQ pulse 2 cycles, pattern 0 -> LV high 6 cycles after req sampled; 4 bursts
//   of 8, gaps of 3; D row0 = 0..7, row3 = 3..10; frame_done once; frame_cnt=1.
// - Second frame, pattern 0 -> row0 D = 1..8 (frame_cnt offset); 32 valid pixels total.
// - Pattern 3, box_x=6, box_y=3 -> 3FF only at (6,3),(7,3); box clipped at x=8; rest 040.
// - FRAME_REQ rise during LINE -> frame unaffected, req_overrun=1 and stays 1 until reset.
// - Reset asserted mid-line -> next cycle LV=DV=0, D=0, busy=0; new FRAME_REQ gives full frame.
// - Pattern 2 const_val=0x155, const_val changed mid-frame to 0x2AA -> all pixels 0x155.

Source files
------------

// File: rtl/cvm300_sensor_emulator_if.sv
// Bundle of the CVM300 parallel pixel port plus the frame control/status
// signals exchanged between the capture logic and the sensor emulator.
// master: capture side (requests frames, chooses pattern).
// slave : sensor emulator (produces Line_valid/Data_valid/D and status).
interface cvm300_sensor_emulator_if;
    logic        FRAME_REQ;
    logic [1:0]  pattern_sel;
    logic [9:0]  const_val;
    logic [9:0]  box_x;
    logic [9:0]  box_y;
    logic        CVM300_Line_valid;
    logic        CVM300_Data_valid;
    logic [9:0]  CVM300_D;
    logic        frame_busy;
    logic        frame_done;
    logic        req_overrun;
    logic [15:0] frame_cnt;

    modport master (
        output FRAME_REQ, pattern_sel, const_val, box_x, box_y,
        input  CVM300_Line_valid, CVM300_Data_valid, CVM300_D,
        input  frame_busy, frame_done, req_overrun, frame_cnt
    );

    modport slave (
        input  FRAME_REQ, pattern_sel, const_val, box_x, box_y,
        output CVM300_Line_valid, CVM300_Data_valid, CVM300_D,
        output frame_busy, frame_done, req_overrun, frame_cnt
    );
endinterface

// File: rtl/cvm300_sensor_emulator.sv
// CVM300 image sensor emulator: answers a FRAME_REQ rising edge with one
// frame of Line_valid/Data_valid/D traffic carrying a synthetic pattern
// (ramp, checkerboard, constant, or a movable bright box on a dark field).
module cvm300_sensor_emulator #(
    parameter int H_ACTIVE   = 648,
    parameter int V_LINES    = 488,
    parameter int H_BLANK    = 16,
    parameter int FOT_CYCLES = 64,
    parameter int BOX_SIZE   = 32
) (
    input logic                    CVM_Clk,
    input logic                    reset,
    cvm300_sensor_emulator_if.slave bus
);

    localparam logic [10:0] X_LAST   = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_LAST   = 11'(V_LINES - 1);
    localparam logic [15:0] FOT_LAST = 16'(FOT_CYCLES - 1);
    localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);
    localparam logic [10:0] BOX_W    = 11'(BOX_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FOT,
        S_LINE,
        S_HBLANK,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_n;
    logic        req_q;
    logic        rise;
    logic [15:0] cnt_p0;
    logic [10:0] x_p0;
    logic [10:0] y_p0;
    logic [1:0]  sel_cfg;
    logic [9:0]  cval_cfg;
    logic [9:0]  bx_cfg;
    logic [9:0]  by_cfg;
    logic        vld_p1;
    logic [9:0]  d_p1;
    logic [15:0] frame_cnt;
    logic        overrun;

    // Pixel value for column px / row py. Box bounds are widened to 11 bits
    // so a box near the right/bottom edge is clipped instead of wrapping.
    function automatic logic [9:0] pixel_fn(
        input logic [1:0]  sel,
        input logic [10:0] px,
        input logic [10:0] py,
        input logic [9:0]  fc,
        input logic [9:0]  cval,
        input logic [9:0]  bx,
        input logic [9:0]  by
    );
        logic [10:0] bx_w;
        logic [10:0] by_w;
        logic        in_box;
        bx_w   = {1'b0, bx};
        by_w   = {1'b0, by};
        in_box = (px >= bx_w) && (px < bx_w + BOX_W) &&
                 (py >= by_w) && (py < by_w + BOX_W);
        case (sel)
            2'd0:    pixel_fn = px[9:0] + py[9:0] + fc;
            2'd1:    pixel_fn = (px[3] ^ py[3]) ? 10'h3FF : 10'h000;
            2'd2:    pixel_fn = cval;
            default: pixel_fn = in_box ? 10'h3FF : 10'h040;
        endcase
    endfunction

    assign rise = bus.FRAME_REQ & ~req_q;

    // Register FRAME_REQ once for edge detection.
    always_ff @(posedge CVM_Clk) begin
        if (reset) req_q <= 1'b0;
        else       req_q <= bus.FRAME_REQ;
    end

    // Capture the pattern configuration at frame start; it holds for the whole frame.
    always_ff @(posedge CVM_Clk) begin
        if (state == S_IDLE && rise) begin
            sel_cfg  <= bus.pattern_sel;
            cval_cfg <= bus.const_val;
            bx_cfg   <= bus.box_x;
            by_cfg   <= bus.box_y;
        end
    end

    // Frame sequencer state register.
    always_ff @(posedge CVM_Clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Frame sequencer next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (rise) state_n = S_FOT;
            S_FOT:    if (cnt_p0 == FOT_LAST) state_n = S_LINE;
            S_LINE:   if (x_p0 == X_LAST) state_n = S_HBLANK;
            S_HBLANK: if (cnt_p0 == HB_LAST) state_n = (y_p0 == Y_LAST) ? S_DONE : S_LINE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Stage p0: cycle counter (FOT / HBLANK) and pixel position.
    always_ff @(posedge CVM_Clk) begin
        if (reset) begin
            cnt_p0 <= '0;
            x_p0   <= '0;
            y_p0   <= '0;
        end else begin
            case (state)
                S_FOT: begin
                    cnt_p0 <= (cnt_p0 == FOT_LAST) ? 16'd0 : cnt_p0 + 16'd1;
                end
                S_LINE: begin
                    if (x_p0 != X_LAST) x_p0 <= x_p0 + 11'd1;
                end
                S_HBLANK: begin
                    if (cnt_p0 == HB_LAST) begin
                        cnt_p0 <= '0;
                        x_p0   <= '0;
                        if (y_p0 != Y_LAST) y_p0 <= y_p0 + 11'd1;
                    end else begin
                        cnt_p0 <= cnt_p0 + 16'd1;
                    end
                end
                default: begin
                    cnt_p0 <= '0;
                    x_p0   <= '0;
                    y_p0   <= '0;
                end
            endcase
        end
    end

    // Frame counter advances as the sequencer enters DONE; sticky overrun flag.
    always_ff @(posedge CVM_Clk) begin
        if (reset) begin
            frame_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            if (state == S_HBLANK && state_n == S_DONE) frame_cnt <= frame_cnt + 16'd1;
            if (rise && state != S_IDLE) overrun <= 1'b1;
        end
    end

    // Stage p1: registered pixel port, D forced to zero outside active pixels.
    always_ff @(posedge CVM_Clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            d_p1   <= '0;
        end else begin
            vld_p1 <= (state == S_LINE);
            d_p1   <= (state == S_LINE) ?
                      pixel_fn(sel_cfg, x_p0, y_p0, frame_cnt[9:0], cval_cfg, bx_cfg, by_cfg) :
                      10'd0;
        end
    end

    assign bus.CVM300_Line_valid = vld_p1;
    assign bus.CVM300_Data_valid = vld_p1;
    assign bus.CVM300_D          = d_p1;
    assign bus.frame_busy        = (state == S_FOT) || (state == S_LINE) || (state == S_HBLANK);
    assign bus.frame_done        = (state == S_DONE);
    assign bus.req_overrun       = overrun;
    assign bus.frame_cnt         = frame_cnt;

endmodule

// File: tb/tb_cvm300_sensor_emulator.sv
// Testbench for cvm300_sensor_emulator with a reduced frame geometry.
module tb_cvm300_sensor_emulator;

    localparam int H       = 8;
    localparam int V       = 4;
    localparam int HB      = 3;
    localparam int FOT     = 5;
    localparam int BOX     = 2;
    localparam int P       = H + HB;
    localparam int FRAME_T = FOT + V * P;   // cycle index of the frame_done pulse

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cvm300_sensor_emulator_if bus();

    cvm300_sensor_emulator #(
        .H_ACTIVE  (H),
        .V_LINES   (V),
        .H_BLANK   (HB),
        .FOT_CYCLES(FOT),
        .BOX_SIZE  (BOX)
    ) dut (
        .CVM_Clk(clk),
        .reset  (rst),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int exp_fc = 0;

    typedef struct {
        int sel;
        int cv;
        int bx;
        int by;
        int exp_first;
        int exp_last;
        int exp_hits;
        int exp_sum;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference pixel rule, in plain integer arithmetic.
    function automatic int model_px(input int sel, input int x, input int y, input int fc,
                                    input int cv, input int bx, input int by);
        case (sel)
            0: return (x + y + fc) % 1024;
            1: return (((x / 8) % 2) != ((y / 8) % 2)) ? 1023 : 0;
            2: return cv;
            default: return (x >= bx && x < bx + BOX && y >= by && y < by + BOX) ? 1023 : 64;
        endcase
    endfunction

    // Request one frame (FRAME_REQ high two cycles) and check every cycle of the
    // frame window against the reference timeline.
    task automatic run_frame(input int sel, input int cv, input int bx, input int by,
                             input bit scramble, input int rise_at, input int cv_change,
                             output int nvalid, output int sum, output int hits,
                             output int first_px, output int last_px);
        int rel, exp_lv, exp_d, exp_busy, exp_done, act, expv;
        nvalid = 0; sum = 0; hits = 0; first_px = -1; last_px = -1;
        @(posedge clk); #1;
        bus.pattern_sel = 2'(sel);
        bus.const_val   = 10'(cv);
        bus.box_x       = 10'(bx);
        bus.box_y       = 10'(by);
        bus.FRAME_REQ   = 1'b1;
        for (int t = 0; t <= FRAME_T + 6; t++) begin
            @(posedge clk); #1;
            if (t == 1) bus.FRAME_REQ = 1'b0;
            if (t == rise_at) bus.FRAME_REQ = 1'b1;
            if (t == rise_at + 1) bus.FRAME_REQ = 1'b0;
            if (cv_change >= 0 && t == 20) bus.const_val = 10'(cv_change);
            if (scramble) begin
                bus.pattern_sel = 2'($urandom_range(0, 3));
                bus.const_val   = 10'($urandom_range(0, 1023));
                bus.box_x       = 10'($urandom_range(0, 1023));
                bus.box_y       = 10'($urandom_range(0, 1023));
            end
            @(negedge clk);
            rel      = t - (FOT + 1);
            exp_lv   = (rel >= 0 && rel < V * P && (rel % P) < H) ? 1 : 0;
            exp_d    = exp_lv ? model_px(sel, rel % P, rel / P, exp_fc, cv, bx, by) : 0;
            exp_busy = (t < FRAME_T) ? 1 : 0;
            exp_done = (t == FRAME_T) ? 1 : 0;
            expv = (exp_lv << 13) | (exp_lv << 12) | (exp_busy << 11) | (exp_done << 10) | exp_d;
            act  = int'({bus.CVM300_Line_valid, bus.CVM300_Data_valid,
                         bus.frame_busy, bus.frame_done, bus.CVM300_D});
            check($sformatf("trace t=%0d {lv,dv,busy,done,D}", t), act, expv);
            if (bus.CVM300_Data_valid) begin
                nvalid++;
                sum += int'(bus.CVM300_D);
                if (bus.CVM300_D == 10'h3FF) hits++;
                if (first_px < 0) first_px = int'(bus.CVM300_D);
                last_px = int'(bus.CVM300_D);
            end
        end
        exp_fc = (exp_fc + 1) % 65536;
        check("frame_cnt", int'(bus.frame_cnt), exp_fc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv, sm, ht, fp, lp;
        int found;

        vecs[0] = '{3, 0,     6,    3,    10'h040, 10'h3FF, 2, 3966};
        vecs[1] = '{2, 10'h155, 0,  0,    10'h155, 10'h155, 0, 10912};
        vecs[2] = '{1, 0,     0,    0,    0,       0,       0, 0};
        vecs[3] = '{0, 0,     0,    0,    5,       15,      0, 320};
        vecs[4] = '{3, 0,     0,    0,    10'h3FF, 10'h040, 4, 5884};
        vecs[5] = '{3, 0,     1023, 1023, 10'h040, 10'h040, 0, 2048};

        bus.FRAME_REQ = 1'b0;
        bus.pattern_sel = 2'd0;
        bus.const_val = 10'd0;
        bus.box_x = 10'd0;
        bus.box_y = 10'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset lv", int'(bus.CVM300_Line_valid), 0);
        check("reset dv", int'(bus.CVM300_Data_valid), 0);
        check("reset D", int'(bus.CVM300_D), 0);
        check("reset busy", int'(bus.frame_busy), 0);
        check("reset done", int'(bus.frame_done), 0);
        check("reset overrun", int'(bus.req_overrun), 0);
        check("reset frame_cnt", int'(bus.frame_cnt), 0);
        rst = 1'b0;

        // First two ramp frames: row0 shifts by the frame count.
        run_frame(0, 0, 0, 0, 1'b0, -1, -1, nv, sm, ht, fp, lp);
        check("f1 valid count", nv, 32);
        check("f1 first px", fp, 0);
        check("f1 last px", lp, 10);
        run_frame(0, 0, 0, 0, 1'b0, -1, -1, nv, sm, ht, fp, lp);
        check("f2 valid count", nv, 32);
        check("f2 first px", fp, 1);
        check("f2 last px", lp, 11);

        // Table of pattern configurations with hand-derived frame statistics.
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].sel, vecs[i].cv, vecs[i].bx, vecs[i].by, 1'b0, -1, -1,
                      nv, sm, ht, fp, lp);
            check($sformatf("vec%0d valid", i), nv, 32);
            check($sformatf("vec%0d first", i), fp, vecs[i].exp_first);
            check($sformatf("vec%0d last", i), lp, vecs[i].exp_last);
            check($sformatf("vec%0d hits", i), ht, vecs[i].exp_hits);
            check($sformatf("vec%0d sum", i), sm, vecs[i].exp_sum);
        end

        // Constant pattern with const_val changed mid-frame.
        run_frame(2, 10'h155, 0, 0, 1'b0, -1, 10'h2AA, nv, sm, ht, fp, lp);
        check("const change sum", sm, 32 * 10'h155);
        check("const change last", lp, 10'h155);

        // Randomized configurations, inputs scrambled throughout the frame.
        for (int i = 0; i < 4; i++) begin
            run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)),
                      int'($urandom_range(0, 9)), int'($urandom_range(0, 5)),
                      1'b1, -1, -1, nv, sm, ht, fp, lp);
            check($sformatf("rand%0d valid", i), nv, 32);
        end

        // Request during LINE: frame unaffected, overrun sticks.
        check("overrun before", int'(bus.req_overrun), 0);
        run_frame(0, 0, 0, 0, 1'b0, FOT + 3, -1, nv, sm, ht, fp, lp);
        check("overrun after line req", int'(bus.req_overrun), 1);
        run_frame(1, 0, 0, 0, 1'b0, -1, -1, nv, sm, ht, fp, lp);
        check("overrun sticky", int'(bus.req_overrun), 1);

        // Reset in the middle of a line.
        @(posedge clk); #1;
        bus.pattern_sel = 2'd0;
        bus.FRAME_REQ = 1'b1;
        @(posedge clk); #1;
        bus.FRAME_REQ = 1'b0;
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            @(negedge clk);
            if (bus.CVM300_Line_valid) found = 1;
        end
        check("lv before mid reset", found, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset lv", int'(bus.CVM300_Line_valid), 0);
        check("midreset dv", int'(bus.CVM300_Data_valid), 0);
        check("midreset D", int'(bus.CVM300_D), 0);
        check("midreset busy", int'(bus.frame_busy), 0);
        check("midreset overrun", int'(bus.req_overrun), 0);
        check("midreset frame_cnt", int'(bus.frame_cnt), 0);
        rst = 1'b0;
        exp_fc = 0;

        // Fresh frame after reset; a request landing in the DONE cycle is ignored.
        run_frame(0, 0, 0, 0, 1'b0, FRAME_T, -1, nv, sm, ht, fp, lp);
        check("post reset valid", nv, 32);
        check("post reset first", fp, 0);
        check("overrun from done req", int'(bus.req_overrun), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
